// File: rtl/cpu_pkg.sv
// Shared definitions for the plotter CPU: widths, opcodes, instruction
// field positions and the control FSM state encoding.
package cpu_pkg;

    localparam int PC_WIDTH        = 10;
    localparam int DATA_ADDR_WIDTH = 8;
    localparam int WORD_WIDTH      = 16;
    localparam int ACCEL_ID_WIDTH  = 4;
    localparam int REG_ADDR_WIDTH  = 4;
    localparam int NUM_REGS        = 16;

    // Instruction field bit positions
    localparam int OP_MSB = 15;
    localparam int OP_LSB = 12;
    localparam int RD_MSB = 11;
    localparam int RD_LSB = 8;
    localparam int RS_MSB = 7;
    localparam int RS_LSB = 4;
    localparam int ID_MSB = 3;
    localparam int ID_LSB = 0;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_MOV  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_BZ   = 4'hB;
    localparam logic [3:0] OP_BNZ  = 4'hC;
    localparam logic [3:0] OP_ARD  = 4'hD;
    localparam logic [3:0] OP_AWR  = 4'hE;
    localparam logic [3:0] OP_ADDI = 4'hF;

    // HALTED is only reachable when the halt instruction is compiled in
    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_EXEC   = 2'd1,
        ST_LOAD   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    function automatic logic [WORD_WIDTH-1:0] sext8(input logic [7:0] v);
        return {{(WORD_WIDTH-8){v[7]}}, v};
    endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 16x16 general-purpose register file: one synchronous write port and two
// combinational read ports. All registers clear on reset.
module cpu_regfile
    import cpu_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [REG_ADDR_WIDTH-1:0] waddr,
    input  logic [WORD_WIDTH-1:0]     wdata,
    input  logic [REG_ADDR_WIDTH-1:0] raddr_a,
    output logic [WORD_WIDTH-1:0]     rdata_a,
    input  logic [REG_ADDR_WIDTH-1:0] raddr_b,
    output logic [WORD_WIDTH-1:0]     rdata_b
);

    logic [WORD_WIDTH-1:0] regs [NUM_REGS];

    // Register storage with asynchronous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle 16-bit load/store CPU (FETCH -> EXEC [-> LOAD]).
// The instruction ROM output is consumed directly in EXEC/LOAD; pc is held
// until the instruction retires so the ROM keeps presenting the same words.
// Optional: define CPU_HALT_EN to make op 0 with instr[0]=1 a HALT.
module cpu_core
    import cpu_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    output logic [PC_WIDTH-1:0]        instr_mem_addr,
    input  logic [WORD_WIDTH-1:0]      instr_mem_data_0,
    input  logic [WORD_WIDTH-1:0]      instr_mem_data_1,
    output logic [DATA_ADDR_WIDTH-1:0] data_mem_addr,
    input  logic [WORD_WIDTH-1:0]      data_mem_read_data,
    output logic                       data_mem_write_enable,
    output logic [WORD_WIDTH-1:0]      data_mem_write_data,
    output logic [ACCEL_ID_WIDTH-1:0]  accel_id,
    input  logic                       accel_can_read,
    input  logic                       accel_can_write,
    output logic                       accel_read_enable,
    input  logic [WORD_WIDTH-1:0]      accel_read_data,
    output logic                       accel_write_enable,
    output logic [WORD_WIDTH-1:0]      accel_write_data
);

    state_t                    state;
    logic [PC_WIDTH-1:0]       pc;
    logic [PC_WIDTH-1:0]       pc_p1, pc_p2, next_pc;
    logic [WORD_WIDTH-1:0]     instr, imm;
    logic [3:0]                op;
    logic [REG_ADDR_WIDTH-1:0] rd_idx, rs_idx;
    logic [ACCEL_ID_WIDTH-1:0] id;
    logic [WORD_WIDTH-1:0]     rd_val, rs_val;
    logic                      in_exec, exec_done, is_halt;
    logic                      rf_we;
    logic [WORD_WIDTH-1:0]     rf_wdata;

    assign instr   = instr_mem_data_0;
    assign imm     = instr_mem_data_1;
    assign op      = instr[OP_MSB:OP_LSB];
    assign rd_idx  = instr[RD_MSB:RD_LSB];
    assign rs_idx  = instr[RS_MSB:RS_LSB];
    assign id      = instr[ID_MSB:ID_LSB];
    assign in_exec = (state == ST_EXEC);
    assign pc_p1   = pc + PC_WIDTH'(1);
    assign pc_p2   = pc + PC_WIDTH'(2);

`ifdef CPU_HALT_EN
    assign is_halt = (op == OP_NOP) && instr[0];
`else
    assign is_halt = 1'b0;
`endif

    cpu_regfile u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (rf_we),
        .waddr   (rd_idx),
        .wdata   (rf_wdata),
        .raddr_a (rd_idx),
        .rdata_a (rd_val),
        .raddr_b (rs_idx),
        .rdata_b (rs_val)
    );

    assign instr_mem_addr = pc;

    // Memory and accelerator strobes are decoded from the EXEC state so an
    // asynchronous reset (state -> FETCH) removes them immediately.
    assign accel_id = (in_exec && (op == OP_ARD || op == OP_AWR)) ? id : '0;
    assign accel_read_enable  = in_exec && (op == OP_ARD) && accel_can_read;
    assign accel_write_enable = in_exec && (op == OP_AWR) && accel_can_write;
    assign accel_write_data   = (in_exec && op == OP_AWR) ? rs_val : '0;

    assign data_mem_write_enable = in_exec && (op == OP_ST);
    assign data_mem_write_data   = (in_exec && op == OP_ST) ? rs_val : '0;
    assign data_mem_addr = !in_exec        ? '0 :
                           (op == OP_ST)   ? rd_val[DATA_ADDR_WIDTH-1:0] :
                           (op == OP_LD)   ? rs_val[DATA_ADDR_WIDTH-1:0] : '0;

    // Retire condition and next pc for an instruction sitting in EXEC
    always_comb begin
        exec_done = 1'b1;
        next_pc   = pc_p1;
        case (op)
            OP_LDI:  next_pc = pc_p2;
            OP_JMP:  next_pc = imm[PC_WIDTH-1:0];
            OP_BZ:   next_pc = (rs_val == '0) ? imm[PC_WIDTH-1:0] : pc_p2;
            OP_BNZ:  next_pc = (rs_val != '0) ? imm[PC_WIDTH-1:0] : pc_p2;
            OP_ARD:  exec_done = accel_can_read;
            OP_AWR:  exec_done = accel_can_write;
            default: ;
        endcase
    end

    // Register write-back: EXEC for ALU/move/immediate/accel-read, LOAD for LD
    always_comb begin
        rf_we    = 1'b0;
        rf_wdata = '0;
        if (state == ST_LOAD) begin
            rf_we    = 1'b1;
            rf_wdata = data_mem_read_data;
        end else if (in_exec) begin
            case (op)
                OP_LDI:  begin rf_we = 1'b1; rf_wdata = imm;             end
                OP_MOV:  begin rf_we = 1'b1; rf_wdata = rs_val;          end
                OP_ADD:  begin rf_we = 1'b1; rf_wdata = rd_val + rs_val; end
                OP_SUB:  begin rf_we = 1'b1; rf_wdata = rd_val - rs_val; end
                OP_AND:  begin rf_we = 1'b1; rf_wdata = rd_val & rs_val; end
                OP_OR:   begin rf_we = 1'b1; rf_wdata = rd_val | rs_val; end
                OP_XOR:  begin rf_we = 1'b1; rf_wdata = rd_val ^ rs_val; end
                OP_ADDI: begin rf_we = 1'b1; rf_wdata = rd_val + sext8(instr[7:0]); end
                OP_ARD:  begin rf_we = accel_can_read; rf_wdata = accel_read_data; end
                default: ;
            endcase
        end
    end

    // Control FSM and program counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_FETCH;
            pc    <= '0;
        end else begin
            case (state)
                ST_FETCH: state <= ST_EXEC;
                ST_EXEC: begin
                    if (is_halt) begin
                        state <= ST_HALTED;
                    end else if (op == OP_LD) begin
                        state <= ST_LOAD;
                    end else if (exec_done) begin
                        state <= ST_FETCH;
                        pc    <= next_pc;
                    end
                end
                ST_LOAD: begin
                    state <= ST_FETCH;
                    pc    <= pc_p1;
                end
                ST_HALTED: state <= ST_HALTED;
                default:   state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: tb-side ROM/RAM models, cycle-exact checks
// of pc, memory strobes and accelerator handshake.
module tb_cpu_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  instr_mem_addr;
    logic [15:0] instr_mem_data_0, instr_mem_data_1;
    logic [7:0]  data_mem_addr;
    logic [15:0] data_mem_read_data;
    logic        data_mem_write_enable;
    logic [15:0] data_mem_write_data;
    logic [3:0]  accel_id;
    logic        accel_can_read, accel_can_write;
    logic        accel_read_enable, accel_write_enable;
    logic [15:0] accel_read_data, accel_write_data;

    logic [15:0] rom [1024];
    logic [15:0] ram [256];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    cpu_core dut (
        .clk                   (clk),
        .rst                   (rst),
        .instr_mem_addr        (instr_mem_addr),
        .instr_mem_data_0      (instr_mem_data_0),
        .instr_mem_data_1      (instr_mem_data_1),
        .data_mem_addr         (data_mem_addr),
        .data_mem_read_data    (data_mem_read_data),
        .data_mem_write_enable (data_mem_write_enable),
        .data_mem_write_data   (data_mem_write_data),
        .accel_id              (accel_id),
        .accel_can_read        (accel_can_read),
        .accel_can_write       (accel_can_write),
        .accel_read_enable     (accel_read_enable),
        .accel_read_data       (accel_read_data),
        .accel_write_enable    (accel_write_enable),
        .accel_write_data      (accel_write_data)
    );

    // Registered dual-word instruction ROM
    always @(posedge clk) begin
        instr_mem_data_0 <= rom[instr_mem_addr];
        instr_mem_data_1 <= rom[instr_mem_addr + 10'd1];
    end

    // Registered data RAM
    always @(posedge clk) begin
        if (data_mem_write_enable) ram[data_mem_addr] <= data_mem_write_data;
        data_mem_read_data <= ram[data_mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 16'h0000;
        for (int i = 0; i < 256; i++)  ram[i] = 16'h0000;
        rom[0]  = 16'h1100; rom[1]  = 16'h1234;   // LDI r1,0x1234
        rom[2]  = 16'h1200; rom[3]  = 16'h0001;   // LDI r2,1
        rom[4]  = 16'h3120;                       // ADD r1,r2
        rom[5]  = 16'h1300; rom[6]  = 16'h0010;   // LDI r3,0x10
        rom[7]  = 16'h9310;                       // ST [r3],r1
        rom[8]  = 16'h8430;                       // LD r4,[r3]
        rom[9]  = 16'hE041;                       // AWR id1,r4
        rom[10] = 16'h1500; rom[11] = 16'h0003;   // LDI r5,3
        rom[12] = 16'hF5FF;                       // ADDI r5,-1
        rom[13] = 16'hC050; rom[14] = 16'h000C;   // BNZ r5,12
        rom[15] = 16'hE051;                       // AWR id1,r5
        rom[16] = 16'h1700; rom[17] = 16'hFFFF;   // LDI r7,0xFFFF
        rom[18] = 16'hF701;                       // ADDI r7,1
        rom[19] = 16'hE071;                       // AWR id1,r7
        rom[20] = 16'hD604;                       // ARD r6,id4
        rom[21] = 16'hE062;                       // AWR id2,r6
        rom[22] = 16'hB000; rom[23] = 16'h0019;   // BZ r0,25
        rom[25] = 16'hA000; rom[26] = 16'h001B;   // JMP 27
        rom[27] = 16'hD803;                       // ARD r8,id3

        rst = 1'b0;
        accel_can_read  = 1'b0;
        accel_can_write = 1'b1;
        accel_read_data = 16'h0000;

        @(negedge clk);
        chk("rst_pc",   instr_mem_addr, 0);
        chk("rst_dwe",  data_mem_write_enable, 0);
        chk("rst_are",  accel_read_enable, 0);
        chk("rst_awe",  accel_write_enable, 0);
        chk("rst_aid",  accel_id, 0);
        rst = 1'b1;

        step(1); chk("ldi_exec_pc", instr_mem_addr, 0);
        step(1); chk("ldi1_pc", instr_mem_addr, 2);
        step(2); chk("ldi2_pc", instr_mem_addr, 4);
        step(2); chk("add_pc",  instr_mem_addr, 5);
        step(3);                                         // ST in EXEC
        chk("st_we",   data_mem_write_enable, 1);
        chk("st_addr", data_mem_addr, 8'h10);
        chk("st_data", data_mem_write_data, 16'h1235);
        step(1);
        chk("st_we_drop", data_mem_write_enable, 0);
        chk("st_pc",      instr_mem_addr, 8);
        step(1);                                         // LD in EXEC
        chk("ld_addr", data_mem_addr, 8'h10);
        chk("ld_we",   data_mem_write_enable, 0);
        step(1); chk("ld_load_pc", instr_mem_addr, 8);
        step(1); chk("ld_pc",      instr_mem_addr, 9);
        step(1);                                         // AWR r4
        chk("ld_r4_awe",  accel_write_enable, 1);
        chk("ld_r4_aid",  accel_id, 1);
        chk("ld_r4_data", accel_write_data, 16'h1235);
        step(1);
        chk("awr_aid_clr", accel_id, 0);
        chk("awr_pc",      instr_mem_addr, 10);
        step(6); chk("bnz_taken_pc", instr_mem_addr, 12);
        step(8); chk("bnz_fall_pc",  instr_mem_addr, 15);
        step(1); chk("loop_r5_zero", accel_write_data, 16'h0000);
        chk("loop_awe", accel_write_enable, 1);
        step(6); chk("addi_wrap",    accel_write_data, 16'h0000);
        step(1); chk("ard_pc", instr_mem_addr, 20);

        // ARD stall: can_read low for 5 EXEC cycles
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("ard_stall_are", accel_read_enable, 0);
            chk("ard_stall_aid", accel_id, 4);
            chk("ard_stall_pc",  instr_mem_addr, 20);
        end
        accel_can_read  = 1'b1;
        accel_read_data = 16'h0041;
        #1 chk("ard_are", accel_read_enable, 1);
        step(1);
        accel_can_read = 1'b0;
        #1;
        chk("ard_are_drop", accel_read_enable, 0);
        chk("ard_aid_clr",  accel_id, 0);
        chk("ard_done_pc",  instr_mem_addr, 21);
        step(1);                                         // AWR r6, can_write high
        chk("awr_first_exec", accel_write_enable, 1);
        chk("awr_aid",        accel_id, 2);
        chk("ard_r6",         accel_write_data, 16'h0041);
        step(1); chk("awr2_aid_clr", accel_id, 0);
        chk("awr2_pc", instr_mem_addr, 22);
        step(2); chk("bz_taken_pc", instr_mem_addr, 25);
        step(2); chk("jmp_pc",      instr_mem_addr, 27);
        step(1); chk("ard3_aid",    accel_id, 3);

        // Reset during an accelerator stall
        step(1);
        accel_can_read = 1'b1;
        #1 chk("pre_rst_are", accel_read_enable, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_are", accel_read_enable, 0);
        chk("mid_rst_aid", accel_id, 0);
        chk("mid_rst_pc",  instr_mem_addr, 0);
        accel_can_read = 1'b0;
        rom[0] = 16'hE062;                               // AWR id2,r6
        rom[1] = 16'hE012;                               // AWR id2,r1
        rom[2] = 16'h0001;                               // HALT or NOP
        rom[3] = 16'hE012;
        step(2);
        rst = 1'b1;
        step(1);
        chk("post_rst_awe", accel_write_enable, 1);
        chk("post_rst_r6",  accel_write_data, 16'h0000);
        step(2);
        chk("post_rst_r1",  accel_write_data, 16'h0000);
        chk("post_rst_pc",  instr_mem_addr, 1);
        step(1); chk("pre_halt_pc", instr_mem_addr, 2);
`ifdef CPU_HALT_EN
        step(4);
        chk("halt_pc",  instr_mem_addr, 2);
        chk("halt_awe", accel_write_enable, 0);
        chk("halt_dwe", data_mem_write_enable, 0);
`else
        step(2);
        chk("nop1_pc", instr_mem_addr, 3);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
